// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocation, out-of-order completion via CDB, in-order commit.
// A mispredicted branch at commit flushes every entry and pulses flush for one cycle.
module rob_commit_queue #(
    parameter int unsigned ROB_SIZE_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic                     alloc_wen,
    input  logic [4:0]               alloc_rd,
    output logic                     alloc_ready,
    output logic [ROB_SIZE_BITS:0]   alloc_roben,
    input  logic                     cdb_valid,
    input  logic [ROB_SIZE_BITS:0]   cdb_roben,
    input  logic [31:0]              cdb_data,
    input  logic                     cdb_mispredict,
    input  logic [ROB_SIZE_BITS:0]   rd_roben1,
    input  logic [ROB_SIZE_BITS:0]   rd_roben2,
    output logic                     rd_ready1,
    output logic                     rd_ready2,
    output logic [31:0]              rd_data1,
    output logic [31:0]              rd_data2,
    output logic                     commit_wen,
    output logic [ROB_SIZE_BITS:0]   commit_roben,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_data,
    output logic                     flush,
    output logic [ROB_SIZE_BITS:0]   count
);

    localparam int unsigned DEPTH = 2 ** ROB_SIZE_BITS;
    localparam int unsigned TW    = ROB_SIZE_BITS + 1;
    localparam int unsigned IW    = ROB_SIZE_BITS;

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_ready;
    logic [DEPTH-1:0] e_misp;
    logic [DEPTH-1:0] e_wen;
    logic [4:0]       e_rd   [DEPTH];
    logic [31:0]      e_data [DEPTH];

    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW-1:0] cdb_idx;
    logic          cdb_hit;
    logic          alloc_go;
    logic          commit_go;
    logic          commit_flush;

    // Tags above DEPTH are representable in TW bits but name no entry.
    function automatic logic tag_in_range(input logic [TW-1:0] tag);
        return (tag != '0) && (tag <= TW'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] tag_idx(input logic [TW-1:0] tag);
        logic [TW-1:0] t;
        t = tag - TW'(1);
        return t[IW-1:0];
    endfunction

    // Operand lookup: same-cycle CDB bypass takes priority over stored results.
    function automatic logic [32:0] lookup(input logic [TW-1:0] tag);
        logic [IW-1:0] idx;
        idx = tag_idx(tag);
        if (tag == '0)
            return '0;
        if (cdb_valid && (cdb_roben == tag))
            return {1'b1, cdb_data};
        if (tag_in_range(tag) && e_valid[idx] && e_ready[idx])
            return {1'b1, e_data[idx]};
        return '0;
    endfunction

    always_comb begin
        alloc_ready  = (count < TW'(DEPTH)) && !flush;
        alloc_roben  = TW'(tail) + TW'(1);
        alloc_go     = alloc_valid && alloc_ready;
        cdb_idx      = tag_idx(cdb_roben);
        cdb_hit      = cdb_valid && tag_in_range(cdb_roben) && e_valid[cdb_idx];
        commit_go    = e_valid[head] && e_ready[head];
        commit_flush = commit_go && e_misp[head];
    end

    always_comb begin
        {rd_ready1, rd_data1} = lookup(rd_roben1);
        {rd_ready2, rd_data2} = lookup(rd_roben2);
    end

    // Pointers, occupancy and registered commit/flush outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_wen   <= 1'b0;
            commit_roben <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
            flush        <= 1'b0;
        end else begin
            commit_wen <= 1'b0;
            flush      <= 1'b0;
            if (commit_go) begin
                commit_wen   <= e_wen[head] && (e_rd[head] != 5'd0);
                commit_roben <= TW'(head) + TW'(1);
                commit_rd    <= e_rd[head];
                commit_data  <= e_data[head];
            end
            if (commit_flush) begin
                flush <= 1'b1;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (commit_go)
                    head <= head + IW'(1);
                if (alloc_go)
                    tail <= tail + IW'(1);
                if (alloc_go && !commit_go)
                    count <= count + TW'(1);
                else if (!alloc_go && commit_go)
                    count <= count - TW'(1);
            end
        end
    end

    // Entry storage; commit clear is last so it wins over a CDB write to the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid <= '0;
            e_ready <= '0;
            e_misp  <= '0;
            e_wen   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                e_rd[i]   <= '0;
                e_data[i] <= '0;
            end
        end else if (commit_flush) begin
            e_valid <= '0;
            e_ready <= '0;
            e_misp  <= '0;
        end else begin
            if (cdb_hit) begin
                e_ready[cdb_idx] <= 1'b1;
                e_misp[cdb_idx]  <= cdb_mispredict;
                e_data[cdb_idx]  <= cdb_data;
            end
            if (alloc_go) begin
                e_valid[tail] <= 1'b1;
                e_ready[tail] <= 1'b0;
                e_misp[tail]  <= 1'b0;
                e_wen[tail]   <= alloc_wen;
                e_rd[tail]    <= alloc_rd;
            end
            if (commit_go) begin
                e_valid[head] <= 1'b0;
                e_ready[head] <= 1'b0;
                e_misp[head]  <= 1'b0;
            end
        end
    end

endmodule
